ula_full_stream: RTL and testbench

- Handshaked, pipelined execution wrapper around the ULA core, so the full ULA can be driven as a request/response slave instead of a purely combinational block.
- Accepts operand/op/mode requests on a valid/ready channel, evaluates them in an internal ula_full_behavioral instance, and returns result, flags and tag on a second valid/ready channel, in order.
- Keeps running operation statistics for the system-level self-test controller.

---
 rtl/ula_full_stream_pkg.sv | 19 +
 rtl/ula_full_behavioral.sv | 86 ++++++++
 rtl/ula_resp_fifo.sv | 61 ++++++
 rtl/ula_full_stream.sv | 168 ++++++++++++++++
 tb/tb_ula_full_stream.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_full_stream_pkg.sv
// Shared definitions for the streaming ULA wrapper.
// Holds the response flag bit positions, the highest legal numeric mode
// and the fixed flag pattern returned for an illegal-mode request.
package ula_full_stream_pkg;

    localparam int FLAG_OVF     = 0;
    localparam int FLAG_SAT     = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_NEG     = 3;
    localparam int FLAG_CARRY   = 4;
    localparam int FLAG_ILLEGAL = 5;

    localparam int RSP_FLAGS_W  = 6;

    localparam logic [2:0] NUM_MODE_MAX = 3'd4;

    localparam logic [RSP_FLAGS_W-1:0] ILLEGAL_FLAGS = 6'b100000;

endpackage

// File: rtl/ula_full_behavioral.sv
// ULA core: purely combinational arithmetic/logic unit.
// Ports:
//   a, b       operands
//   op_sel     0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, 6 shl, 7 shr
//   num_mode   0 unsigned wrap, 1 signed wrap, 2 unsigned saturate,
//              3 signed saturate, 4 signed fixed-point (FRAC bits) saturate
//   result     operation result
//   overflow, saturate, zero, negative, carry   status flags
// Arithmetic ops are evaluated exactly in a wide signed value and then
// range-checked against the target number format.
module ula_full_behavioral #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_sel,
    input  logic [2:0]       num_mode,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             saturate,
    output logic             zero,
    output logic             negative,
    output logic             carry
);
    localparam int IW   = 2 * WIDTH + 2;
    localparam int SH_W = $clog2(WIDTH);

    logic                 is_signed;
    logic                 is_sat;
    logic                 arith;
    logic signed [IW-1:0] ea;
    logic signed [IW-1:0] eb;
    logic signed [IW-1:0] prod;
    logic signed [IW-1:0] ideal;
    logic signed [IW-1:0] max_v;
    logic signed [IW-1:0] min_v;
    logic [WIDTH:0]       add_u;
    logic [WIDTH:0]       sub_u;

    always_comb begin
        is_signed = (num_mode == 3'd1) || (num_mode == 3'd3) || (num_mode == 3'd4);
        is_sat    = (num_mode == 3'd2) || (num_mode == 3'd3) || (num_mode == 3'd4);
        ea = is_signed ? {{(IW-WIDTH){a[WIDTH-1]}}, a} : {{(IW-WIDTH){1'b0}}, a};
        eb = is_signed ? {{(IW-WIDTH){b[WIDTH-1]}}, b} : {{(IW-WIDTH){1'b0}}, b};
        prod  = ea * eb;
        add_u = {1'b0, a} + {1'b0, b};
        sub_u = {1'b0, a} - {1'b0, b};
        max_v = is_signed ? {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}}
                          : {{(IW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
        // Two's complement: ~(2^(W-1)-1) == -2^(W-1)
        min_v = is_signed ? ~max_v : '0;

        ideal  = '0;
        arith  = 1'b0;
        carry  = 1'b0;
        result = '0;
        case (op_sel)
            3'd0: begin ideal = ea + eb; arith = 1'b1; carry = add_u[WIDTH]; end
            3'd1: begin ideal = ea - eb; arith = 1'b1; carry = sub_u[WIDTH]; end
            3'd2: begin
                ideal = (num_mode == 3'd4) ? (prod >>> FRAC) : prod;
                arith = 1'b1;
            end
            3'd3: result = a & b;
            3'd4: result = a | b;
            3'd5: result = a ^ b;
            3'd6: result = a << b[SH_W-1:0];
            default: result = is_signed ? WIDTH'($signed(a) >>> b[SH_W-1:0])
                                        : (a >> b[SH_W-1:0]);
        endcase

        overflow = arith && ((ideal > max_v) || (ideal < min_v));
        saturate = overflow && is_sat;
        if (arith) begin
            if (saturate) begin
                result = (ideal > max_v) ? max_v[WIDTH-1:0] : min_v[WIDTH-1:0];
            end else begin
                result = ideal[WIDTH-1:0];
            end
        end
        zero     = (result == '0);
        negative = is_signed && result[WIDTH-1];
    end

endmodule

// File: rtl/ula_resp_fifo.sv
// Synchronous response FIFO.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push, din    write request and data (caller never pushes when full
//                unless popping on the same edge)
//   pop          remove head (caller never pops when empty)
//   dout         head entry, forced to zero while empty
//   full, empty  occupancy status
module ula_resp_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_B = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_B-1:0]  count_q, count_d;

    assign full  = (count_q == CNT_B'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap so non-power-of-two depths work.
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ula_full_stream.sv
// Handshaked, pipelined wrapper around the ULA core.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready                request channel
//   req_a, req_b, req_op, req_mode, req_tag   request payload
//   rsp_valid/rsp_ready                response channel
//   rsp_result, rsp_flags, rsp_tag     response payload, in acceptance order
//   cnt_ops, cnt_ovf, cnt_illegal      delivered-response statistics (wrap)
// Pipeline: input register s1 -> core (combinational) -> response FIFO.
module ula_full_stream
    import ula_full_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH-1:0]       req_a,
    input  logic [WIDTH-1:0]       req_b,
    input  logic [2:0]             req_op,
    input  logic [2:0]             req_mode,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [RSP_FLAGS_W-1:0] rsp_flags,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [CNT_W-1:0]       cnt_ops,
    output logic [CNT_W-1:0]       cnt_ovf,
    output logic [CNT_W-1:0]       cnt_illegal
);
    localparam int ENTRY_W = WIDTH + RSP_FLAGS_W + TAG_W;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [2:0]       s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic fifo_full, fifo_empty, fifo_pop, s1_advance, req_fire;

    logic [WIDTH-1:0]       core_result;
    logic                   core_ovf, core_sat, core_zero, core_neg, core_carry;
    logic [WIDTH-1:0]       s1_result;
    logic [RSP_FLAGS_W-1:0] s1_flags;
    logic [ENTRY_W-1:0]     fifo_dout;

    assign fifo_pop   = !fifo_empty && rsp_ready;
    assign s1_advance = s1_valid_q && (!fifo_full || fifo_pop);
    // Combinational from rsp_ready: lets a full pipeline accept while draining.
    assign req_ready  = !s1_valid_q || s1_advance;
    assign req_fire   = req_valid && req_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = req_a;
            s1_b_d     = req_b;
            s1_op_d    = req_op;
            s1_mode_d  = req_mode;
            s1_tag_d   = req_tag;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_mode_q  <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_mode_q  <= s1_mode_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    ula_full_behavioral #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_core (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .op_sel   (s1_op_q),
        .num_mode (s1_mode_q),
        .result   (core_result),
        .overflow (core_ovf),
        .saturate (core_sat),
        .zero     (core_zero),
        .negative (core_neg),
        .carry    (core_carry)
    );

    // Out-of-range modes bypass the core with a fixed illegal response.
    always_comb begin
        s1_result = core_result;
        s1_flags  = '0;
        s1_flags[FLAG_OVF]   = core_ovf;
        s1_flags[FLAG_SAT]   = core_sat;
        s1_flags[FLAG_ZERO]  = core_zero;
        s1_flags[FLAG_NEG]   = core_neg;
        s1_flags[FLAG_CARRY] = core_carry;
        if (s1_mode_q > NUM_MODE_MAX) begin
            s1_result = '0;
            s1_flags  = ILLEGAL_FLAGS;
        end
    end

    ula_resp_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s1_advance),
        .pop   (fifo_pop),
        .din   ({s1_result, s1_flags, s1_tag_q}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign {rsp_result, rsp_flags, rsp_tag} = fifo_dout;

    // Statistics: 0 = all delivered, 1 = overflow, 2 = illegal.
    logic [2:0]       cnt_hit;
    logic [CNT_W-1:0] cnt_q [3];

    assign cnt_hit[0] = fifo_pop;
    assign cnt_hit[1] = fifo_pop && rsp_flags[FLAG_OVF];
    assign cnt_hit[2] = fifo_pop && rsp_flags[FLAG_ILLEGAL];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_d;
            assign cnt_d = cnt_hit[gi] ? cnt_q[gi] + 1'b1 : cnt_q[gi];
            always_ff @(posedge clk) begin
                if (!rst_n) cnt_q[gi] <= '0;
                else        cnt_q[gi] <= cnt_d;
            end
        end
    endgenerate

    assign cnt_ops     = cnt_q[0];
    assign cnt_ovf     = cnt_q[1];
    assign cnt_illegal = cnt_q[2];

endmodule

// File: tb/tb_ula_full_stream.sv
module tb_ula_full_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [7:0] req_a, req_b;
    logic [2:0] req_op, req_mode;
    logic [3:0] req_tag;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic [5:0] rsp_flags;
    logic [3:0] rsp_tag;
    logic [15:0] cnt_ops, cnt_ovf, cnt_illegal;

    logic [7:0] ref_result;
    logic ref_ovf, ref_sat, ref_zero, ref_neg, ref_carry;

    always #5 clk = ~clk;

    ula_full_stream #(.WIDTH(8), .FRAC(4), .TAG_W(4), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mode(req_mode), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .cnt_ops(cnt_ops), .cnt_ovf(cnt_ovf), .cnt_illegal(cnt_illegal)
    );

    // Reference core evaluated on the request currently being driven.
    ula_full_behavioral #(.WIDTH(8), .FRAC(4)) ref_core (
        .a(req_a), .b(req_b), .op_sel(req_op), .num_mode(req_mode),
        .result(ref_result), .overflow(ref_ovf), .saturate(ref_sat),
        .zero(ref_zero), .negative(ref_neg), .carry(ref_carry)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [5:0] f;
        logic [3:0] t;
    } exp_t;

    typedef struct {
        logic [7:0] a, b;
        logic [2:0] op, mode;
        logic [3:0] tag;
        logic [7:0] er;
        logic [5:0] ef;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];
    int checks = 0;
    int failures = 0;
    int exp_ops = 0, exp_ovf = 0, exp_ill = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           input logic [2:0] mode, input logic [3:0] tag);
        req_a = a; req_b = b; req_op = op; req_mode = mode; req_tag = tag; req_valid = 1'b1;
    endtask

    // One clock: settle, score the response and request handshakes that will
    // occur on the coming edge, then advance to just past that edge.
    task automatic cycle(input bit use_ref, input logic [7:0] er, input logic [5:0] ef,
                         output bit acc);
        exp_t e;
        exp_t got;
        #1;
        acc = req_valid && req_ready;
        if (rsp_valid && rsp_ready) begin
            got = {rsp_result, rsp_flags, rsp_tag};
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {14'd0, got}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp", {14'd0, got}, {14'd0, e});
                exp_ops++;
                if (e.f[0]) exp_ovf++;
                if (e.f[5]) exp_ill++;
            end
        end
        if (acc) begin
            if (!use_ref) e = {er, ef, req_tag};
            else if (req_mode > 3'd4) e = {8'h00, 6'b100000, req_tag};
            else e = {ref_result, 1'b0, ref_carry, ref_neg, ref_zero, ref_sat, ref_ovf, req_tag};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || rsp_valid) && n < 50) begin
            cycle(1'b1, 8'h0, 6'h0, acc);
            n++;
        end
        chk("drain_timeout", n < 50, 1);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_cnt_ops"}, cnt_ops, exp_ops);
        chk({tag, "_cnt_ovf"}, cnt_ovf, exp_ovf);
        chk({tag, "_cnt_ill"}, cnt_illegal, exp_ill);
    endtask

    initial begin
        bit acc;
        int n;
        int accepted;
        int issued;
        int tag;

        vecs[0]  = '{8'h03, 8'h05, 3'd0, 3'd0, 4'h1, 8'h08, 6'b000000};
        vecs[1]  = '{8'hFF, 8'h01, 3'd0, 3'd0, 4'h2, 8'h00, 6'b010101};
        vecs[2]  = '{8'hFF, 8'h01, 3'd0, 3'd2, 4'h3, 8'hFF, 6'b010011};
        vecs[3]  = '{8'h7F, 8'h01, 3'd0, 3'd1, 4'h4, 8'h80, 6'b001001};
        vecs[4]  = '{8'h7F, 8'h01, 3'd0, 3'd3, 4'h5, 8'h7F, 6'b000011};
        vecs[5]  = '{8'h02, 8'h03, 3'd1, 3'd0, 4'h6, 8'hFF, 6'b010001};
        vecs[6]  = '{8'h10, 8'h10, 3'd2, 3'd3, 4'h7, 8'h7F, 6'b000011};
        vecs[7]  = '{8'h10, 8'h20, 3'd2, 3'd4, 4'h8, 8'h20, 6'b000000};
        vecs[8]  = '{8'hF0, 8'h3C, 3'd3, 3'd0, 4'h9, 8'h30, 6'b000000};
        vecs[9]  = '{8'hAA, 8'hAA, 3'd5, 3'd0, 4'hA, 8'h00, 6'b000100};
        vecs[10] = '{8'h80, 8'h01, 3'd7, 3'd1, 4'hB, 8'hC0, 6'b001000};
        vecs[11] = '{8'h01, 8'h03, 3'd6, 3'd0, 4'hC, 8'h08, 6'b000000};
        vecs[12] = '{8'h12, 8'h34, 3'd0, 3'd5, 4'h7, 8'h00, 6'b100000};
        vecs[13] = '{8'h00, 8'h00, 3'd0, 3'd0, 4'hD, 8'h00, 6'b000100};

        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = '0; req_mode = '0; req_tag = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_data", {rsp_result, rsp_flags, rsp_tag}, 0);
        chk_counters("reset");

        // Single op: latency
        rsp_ready = 1'b1;
        set_req(8'h03, 8'h05, 3'd0, 3'd0, 4'h1);
        cycle(1'b1, 8'h0, 6'h0, acc);
        chk("single_accept", acc, 1);
        req_valid = 1'b0;
        chk("single_not_yet", rsp_valid, 0);
        cycle(1'b1, 8'h0, 6'h0, acc);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_tag", rsp_tag, 4'h1);
        chk("single_rsp_result", rsp_result, 8'h08);
        cycle(1'b1, 8'h0, 6'h0, acc);
        chk_counters("single");

        // Table vectors, hand-computed expectations, back-to-back
        for (int i = 0; i < 14; i++) begin
            set_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].mode, vecs[i].tag);
            n = 0;
            do begin
                cycle(1'b0, vecs[i].er, vecs[i].ef, acc);
                n++;
            end while (!acc && n < 20);
            chk("vec_accept", acc, 1);
        end
        drain();
        chk_counters("vectors");
        chk("vectors_illegal_seen", cnt_illegal, 1);

        // Backpressure: only DEPTH+1 accepted while the consumer stalls
        rsp_ready = 1'b0;
        tag = 0; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            set_req(8'(tag), 8'h01, 3'd0, 3'd0, 4'(tag));
            cycle(1'b1, 8'h0, 6'h0, acc);
            if (acc) begin tag++; accepted++; end
        end
        chk("bp_accepted", accepted, 3);
        #1;
        chk("bp_req_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        n = 0;
        while (tag < 5 && n < 20) begin
            set_req(8'(tag), 8'h01, 3'd0, 3'd0, 4'(tag));
            cycle(1'b1, 8'h0, 6'h0, acc);
            if (acc) tag++;
            n++;
        end
        chk("bp_all_accepted", tag, 5);
        drain();
        chk_counters("bp");

        // Full pipeline with simultaneous pop and push
        rsp_ready = 1'b0;
        tag = 0; n = 0;
        while (req_ready && n < 10) begin
            set_req(8'h20 + 8'(tag), 8'h02, 3'd1, 3'd1, 4'(tag));
            cycle(1'b1, 8'h0, 6'h0, acc);
            if (acc) tag++;
            n++;
        end
        chk("full_inflight", tag, 3);
        set_req(8'h55, 8'h0F, 3'd4, 3'd0, 4'h9);
        rsp_ready = 1'b1;
        #1;
        chk("full_pop_accept", req_ready, 1);
        cycle(1'b1, 8'h0, 6'h0, acc);
        chk("full_pop_acc", acc, 1);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("full_still_full", req_ready, 0);
        drain();
        chk_counters("fullpop");

        // Reset mid-stream discards in-flight work
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_req(8'(c), 8'h01, 3'd0, 3'd0, 4'(c + 10));
            cycle(1'b1, 8'h0, 6'h0, acc);
        end
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        exp_ops = 0; exp_ovf = 0; exp_ill = 0;
        chk_counters("midreset");
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("midreset_no_rsp", rsp_valid, 0);
            cycle(1'b1, 8'h0, 6'h0, acc);
        end

        // Exhaustive small sweep against the reference core
        issued = 0; n = 0;
        while ((issued < 10240 || sb.size() != 0) && n < 12000) begin
            if (issued < 10240) begin
                set_req(8'((issued / 16) % 16), 8'(issued % 16), 3'((issued / 256) % 8),
                        3'(issued / 2048), 4'(issued % 16));
            end else begin
                req_valid = 1'b0;
            end
            cycle(1'b1, 8'h0, 6'h0, acc);
            if (acc) issued++;
            n++;
        end
        chk("sweep_issued", issued, 10240);
        chk("sweep_throughput", n <= 10245, 1);
        chk("sweep_cnt_ops", cnt_ops, 10240);
        chk_counters("sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
